mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the core's simple request/response memory bus. This is the bus driven by the instruction fetch and load/store units.
- Accepts single-cycle request pulses (read or write with byte strobes) and services them against an internal word-addressed RAM after a fixed latency.
- Returns a one-cycle response pulse with read data.
- Serves as the simulation/BRAM backing store behind the fetch and memory stages. Holds one in-flight request plus a one-deep pending buffer.

Parameters:
- ADDR_WIDTH, 12, word-index bits; RAM depth = 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, cycles from request sample to response pulse; legal range 1..15.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- request_enable  in  1  one-cycle request pulse from initiator
- mode  in  1  MEMREQ_READ (0) / MEMREQ_WRITE (1)
- addr  in  32  byte address; bits [1:0] ignored
- wdata  in  32  write data
- wstrb  in  4  byte-lane write enables; wstrb[i] covers wdata[8i+7:8i]
- response_enable  out  1  one-cycle response pulse
- data  out  32  read data, valid only while response_enable=1
- busy  out  1  high while a request is in flight
- overrun  out  1  sticky: a request was dropped

Behaviour:
- Reset (async, rstn=0): response_enable=0, data=0, busy=0, overrun=0, state=IDLE, pending buffer empty, latency counter=0. RAM contents are not cleared.
- Reset asserted mid-operation aborts the in-flight and pending requests. No response is issued and no write commits.
- Word index = (addr - BASE_ADDR) >> 2, truncated to ADDR_WIDTH bits. Out-of-range addresses wrap modulo depth.
- FSM states: IDLE, WAIT, RESP.
- IDLE: request_enable=1 at edge N latches mode/addr/wdata/wstrb, loads counter=LATENCY-1, and moves to WAIT (or RESP if LATENCY=1). busy=1 from cycle N+1.
- WAIT: counter decrements each cycle. At 0 the FSM moves to RESP.
- RESP: response_enable=1 for exactly this cycle, which is cycle N+LATENCY.
  - Read: data = RAM[index] including all earlier committed writes.
  - Write: bytes with wstrb set are committed at this edge; data=0.
  - wstrb=0 write: no change, response still issued.
  - Leaving RESP: if pending valid, promote it and restart the counter, so its response comes LATENCY cycles after this one. Otherwise go to IDLE and busy=0.
- Request while state≠IDLE: captured into the pending buffer if it was empty before the edge. Otherwise dropped and overrun<=1 (sticky until reset).
- A request in the RESP cycle with pending already full is dropped.
- Requests are served strictly in order. A write followed by a read to the same word returns the written value.
- response_enable is never high on two consecutive cycles when LATENCY>1. With LATENCY=1, back-to-back pulses are allowed.
- data returns the stored bus word as-is. Byte reordering is the initiator's job.

Optional Feature:
- Macro MEM_RESPONDER_FAULT_EN.
- When defined: adds output fault (1 bit, reset 0), pulsed with response_enable when (addr - BASE_ADDR) >= 4*2**ADDR_WIDTH or addr < BASE_ADDR. A faulting write commits nothing; a faulting read returns data=0.
- When undefined: no fault port; out-of-range addresses wrap as above.

Test Plan:
- Reset then single read: LATENCY=2, preload RAM[3]=32'hDEADBEEF, pulse read addr=32'h0C at cycle 10 -> response_enable=1 only in cycle 12, data=32'hDEADBEEF, busy high cycles 11-12.
- Byte-strobe write: RAM[0]=32'h11223344, write addr=0, wdata=32'hAABBCCDD, wstrb=4'b0101, then read addr=0 -> data=32'h11BB33DD.
- Pending chaining: read addr=4 at cycle 0, read addr=8 at cycle 1 -> responses at cycles 2 and 4 in order with the correct words; overrun stays 0.
- Overrun: three requests on cycles 0,1,1+ (third while pending full) -> only two responses; overrun=1 from the edge after the third request and stays 1.
- Mid-operation reset: rstn low one cycle after a write request to addr=0x10 -> no response_enable, RAM[4] unchanged, all outputs 0.
- Fault (MEM_RESPONDER_FAULT_EN, ADDR_WIDTH=4): read addr=32'h40 -> response with data=0, fault=1. Without the macro the same read returns RAM[0].

Source files
------------

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the core's request/response memory bus. Accepts
// single-cycle read/write request pulses, services them against an internal
// word-addressed RAM after a fixed latency and returns a one-cycle response
// pulse. One request is in flight at a time, with a one-deep pending buffer
// behind it; a request arriving while that buffer is full is dropped and the
// sticky overrun flag is raised.
//
// Parameters:
//   ADDR_WIDTH - word-index bits, RAM depth = 2**ADDR_WIDTH 32-bit words
//   LATENCY    - cycles from request sample to response pulse (1..15)
//   BASE_ADDR  - byte address mapped to word 0
//
// Ports:
//   clk             in   clock
//   rstn            in   asynchronous active-low reset
//   request_enable  in   one-cycle request pulse
//   mode            in   0 = read, 1 = write
//   addr[31:0]      in   byte address, bits [1:0] ignored
//   wdata[31:0]     in   write data
//   wstrb[3:0]      in   byte-lane write enables
//   response_enable out  one-cycle response pulse
//   data[31:0]      out  read data, valid with response_enable
//   busy            out  a request is in flight
//   fault           out  (only with MEM_RESPONDER_FAULT_EN) response is for an
//                        address outside the RAM window
//   overrun         out  sticky: a request was dropped
//
// Optional feature: define MEM_RESPONDER_FAULT_EN to add the fault output.
// Without it, out-of-range addresses wrap modulo the RAM depth.
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        request_enable,
    input  logic        mode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        response_enable,
    output logic [31:0] data,
    output logic        busy,
`ifdef MEM_RESPONDER_FAULT_EN
    output logic        fault,
`endif
    output logic        overrun
);

    localparam int         DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);

    // Backing store; deliberately never reset.
    logic [31:0] mem_r [0:DEPTH-1];

    logic [1:0]            state_r;
    logic [3:0]            cnt_r;

    logic                  act_write_r;
    logic [ADDR_WIDTH-1:0] act_idx_r;
    logic [31:0]           act_wdata_r;
    logic [3:0]            act_wstrb_r;
    logic                  act_bad_r;

    logic                  pend_valid_r;
    logic                  pend_write_r;
    logic [ADDR_WIDTH-1:0] pend_idx_r;
    logic [31:0]           pend_wdata_r;
    logic [3:0]            pend_wstrb_r;
    logic                  pend_bad_r;

    logic [31:0]           off_s;
    logic [ADDR_WIDTH-1:0] req_idx_s;
    logic                  req_bad_s;
    logic                  unused_s;

    logic [1:0]            state_s;
    logic [3:0]            cnt_s;
    logic                  load_req_s;
    logic                  load_pend_s;
    logic                  capture_s;
    logic                  drop_s;
    logic                  fire_s;

    logic                  nxt_write_s;
    logic [ADDR_WIDTH-1:0] nxt_idx_s;
    logic [31:0]           nxt_wdata_s;
    logic [3:0]            nxt_wstrb_s;
    logic                  nxt_bad_s;

    // Word index relative to the base; the subtraction wraps, which gives the
    // modulo-depth behaviour for out-of-range addresses.
    assign off_s     = addr - BASE_ADDR;
    assign req_idx_s = off_s[ADDR_WIDTH+1:2];

`ifdef MEM_RESPONDER_FAULT_EN
    // Below the base (borrow) or beyond the last word of the window.
    assign req_bad_s = (addr < BASE_ADDR) || (|off_s[31:ADDR_WIDTH+2]);
    assign unused_s  = ^off_s[1:0];
`else
    assign req_bad_s = 1'b0;
    assign unused_s  = ^{off_s[31:ADDR_WIDTH+2], off_s[1:0]};
`endif

    // Next-state, pending-buffer and request-acceptance decisions.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        load_req_s  = 1'b0;
        load_pend_s = 1'b0;
        capture_s   = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (request_enable) begin
                    load_req_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    state_s = ST_RESP;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
                if (request_enable) begin
                    if (pend_valid_r) begin
                        drop_s = 1'b1;
                    end else begin
                        capture_s = 1'b1;
                    end
                end else begin
                    capture_s = 1'b0;
                end
            end
            ST_RESP: begin
                // The pending buffer is full before this edge, so a request
                // arriving now has nowhere to go.
                if (pend_valid_r) begin
                    load_pend_s = 1'b1;
                    drop_s      = request_enable;
                end else if (request_enable) begin
                    load_req_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
        if (load_req_s || load_pend_s) begin
            state_s = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            cnt_s   = LAT_M1;
        end else begin
            cnt_s = cnt_s;
        end
    end

    // Request that will be active after this edge; the RAM access uses it so
    // that a LATENCY=1 request is served on the edge that accepts it.
    always_comb begin
        nxt_write_s = act_write_r;
        nxt_idx_s   = act_idx_r;
        nxt_wdata_s = act_wdata_r;
        nxt_wstrb_s = act_wstrb_r;
        nxt_bad_s   = act_bad_r;
        if (load_req_s) begin
            nxt_write_s = mode;
            nxt_idx_s   = req_idx_s;
            nxt_wdata_s = wdata;
            nxt_wstrb_s = wstrb;
            nxt_bad_s   = req_bad_s;
        end else if (load_pend_s) begin
            nxt_write_s = pend_write_r;
            nxt_idx_s   = pend_idx_r;
            nxt_wdata_s = pend_wdata_r;
            nxt_wstrb_s = pend_wstrb_r;
            nxt_bad_s   = pend_bad_r;
        end else begin
            nxt_write_s = act_write_r;
        end
    end

    assign fire_s = (state_s == ST_RESP);

    // FSM, request registers, pending buffer and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r         <= ST_IDLE;
            cnt_r           <= 4'd0;
            act_write_r     <= 1'b0;
            act_idx_r       <= '0;
            act_wdata_r     <= 32'd0;
            act_wstrb_r     <= 4'd0;
            act_bad_r       <= 1'b0;
            pend_valid_r    <= 1'b0;
            pend_write_r    <= 1'b0;
            pend_idx_r      <= '0;
            pend_wdata_r    <= 32'd0;
            pend_wstrb_r    <= 4'd0;
            pend_bad_r      <= 1'b0;
            response_enable <= 1'b0;
            data            <= 32'd0;
            busy            <= 1'b0;
            overrun         <= 1'b0;
`ifdef MEM_RESPONDER_FAULT_EN
            fault           <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            act_write_r <= nxt_write_s;
            act_idx_r   <= nxt_idx_s;
            act_wdata_r <= nxt_wdata_s;
            act_wstrb_r <= nxt_wstrb_s;
            act_bad_r   <= nxt_bad_s;
            if (capture_s) begin
                pend_valid_r <= 1'b1;
                pend_write_r <= mode;
                pend_idx_r   <= req_idx_s;
                pend_wdata_r <= wdata;
                pend_wstrb_r <= wstrb;
                pend_bad_r   <= req_bad_s;
            end else if (load_pend_s) begin
                pend_valid_r <= 1'b0;
            end
            if (drop_s) begin
                overrun <= 1'b1;
            end
            response_enable <= fire_s;
            busy            <= (state_s != ST_IDLE);
            if (fire_s && !nxt_write_s && !nxt_bad_s) begin
                data <= mem_r[nxt_idx_s];
            end else begin
                data <= 32'd0;
            end
`ifdef MEM_RESPONDER_FAULT_EN
            fault <= fire_s && nxt_bad_s;
`endif
        end
    end

    // Byte-lane write commit on the edge that enters the response cycle.
    always_ff @(posedge clk) begin
        if (rstn && fire_s && nxt_write_s && !nxt_bad_s) begin
            for (int b = 0; b < 4; b++) begin
                if (nxt_wstrb_s[b]) begin
                    mem_r[nxt_idx_s][8*b +: 8] <= nxt_wdata_s[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Self-checking bench for mem_responder (ADDR_WIDTH=4, LATENCY=2). A table of
// single transactions with hand-computed expected read data is applied in a
// loop; hand-written sequences cover pending chaining, overrun and a reset in
// the middle of a write. Inputs change and outputs are sampled on the falling
// clock edge.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        request_enable;
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        response_enable;
    logic [31:0] data;
    logic        busy;
    logic        overrun;
`ifdef MEM_RESPONDER_FAULT_EN
    logic        fault;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_data;
        logic        exp_fault;
    } vec_t;

    vec_t vecs [16];

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_WIDTH (4),
        .LATENCY    (LAT),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .request_enable  (request_enable),
        .mode            (mode),
        .addr            (addr),
        .wdata           (wdata),
        .wstrb           (wstrb),
        .response_enable (response_enable),
        .data            (data),
        .busy            (busy),
`ifdef MEM_RESPONDER_FAULT_EN
        .fault           (fault),
`endif
        .overrun         (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic m, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws);
        request_enable = 1'b1;
        mode           = m;
        addr           = a;
        wdata          = wd;
        wstrb          = ws;
    endtask

    // One isolated transaction: checks latency, single pulse, data and busy.
    task automatic do_txn(input vec_t v, input string name);
        int          first_k;
        int          pulses;
        logic [31:0] rd;
        logic        fl;
        first_k = -1;
        pulses  = 0;
        rd      = 32'd0;
        fl      = 1'b0;
        @(negedge clk);
        set_req(v.mode, v.addr, v.wdata, v.wstrb);
        for (int k = 1; k <= LAT + 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                request_enable = 1'b0;
                check({name, " busy"}, {31'd0, busy}, 32'd1);
            end
            if (response_enable) begin
                pulses++;
                if (first_k < 0) begin
                    first_k = k;
                    rd      = data;
`ifdef MEM_RESPONDER_FAULT_EN
                    fl      = fault;
`endif
                end
            end
        end
        check({name, " latency"}, first_k, LAT);
        check({name, " pulses"}, pulses, 32'd1);
        check({name, " data"}, rd, v.exp_data);
        check({name, " idle busy"}, {31'd0, busy}, 32'd0);
`ifdef MEM_RESPONDER_FAULT_EN
        check({name, " fault"}, {31'd0, fl}, {31'd0, v.exp_fault});
`else
        if (fl !== v.exp_fault) begin
            check({name, " fault"}, {31'd0, fl}, {31'd0, v.exp_fault});
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;

        //           mode  addr          wdata         wstrb    exp_data      fault
        vecs[0]  = '{1'b1, 32'h0000_000C, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_000C, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0000, 32'h1122_3344, 4'b1111, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0000, 32'hAABB_CCDD, 4'b0101, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h11BB_33DD, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0003, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0002, 32'h0000_0000, 4'b0000, 32'h11BB_33DD, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0004, 32'hCAFE_F00D, 4'b1111, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0008, 32'h0BAD_C0DE, 4'b1111, 32'h0000_0000, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'b1111, 32'h0000_0000, 1'b0};
`ifdef MEM_RESPONDER_FAULT_EN
        vecs[10] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b1};
        vecs[11] = '{1'b1, 32'h0000_0048, 32'h5566_7788, 4'b1111, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 4'b0000, 32'h0BAD_C0DE, 1'b0};
`else
        vecs[10] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 4'b0000, 32'h11BB_33DD, 1'b0};
        vecs[11] = '{1'b1, 32'h0000_0048, 32'h5566_7788, 4'b1111, 32'h0000_0000, 1'b0};
        vecs[12] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 4'b0000, 32'h5566_7788, 1'b0};
`endif
        vecs[13] = '{1'b1, 32'h0000_0004, 32'hAA00_0000, 4'b1000, 32'h0000_0000, 1'b0};
        vecs[14] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 4'b0000, 32'hAAFE_F00D, 1'b0};
        vecs[15] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'h1234_5678, 1'b0};

        rstn           = 1'b0;
        request_enable = 1'b0;
        mode           = 1'b0;
        addr           = 32'd0;
        wdata          = 32'd0;
        wstrb          = 4'd0;
        repeat (3) @(negedge clk);
        check("reset resp", {31'd0, response_enable}, 32'd0);
        check("reset data", data, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset overrun", {31'd0, overrun}, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Write then read of the same word on consecutive cycles.
        @(negedge clk);
        set_req(1'b1, 32'h0000_0014, 32'h0F0F_1234, 4'b1111);
        @(negedge clk);
        check("chain k1 resp", {31'd0, response_enable}, 32'd0);
        set_req(1'b0, 32'h0000_0014, 32'h0000_0000, 4'b0000);
        @(negedge clk);
        request_enable = 1'b0;
        check("chain k2 resp", {31'd0, response_enable}, 32'd1);
        check("chain k2 data", data, 32'd0);
        @(negedge clk);
        check("chain k3 resp", {31'd0, response_enable}, 32'd0);
        check("chain k3 busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("chain k4 resp", {31'd0, response_enable}, 32'd1);
        check("chain k4 data", data, 32'h0F0F_1234);
        @(negedge clk);
        check("chain k5 resp", {31'd0, response_enable}, 32'd0);
        check("chain k5 busy", {31'd0, busy}, 32'd0);
        check("chain overrun", {31'd0, overrun}, 32'd0);

        // Three back-to-back requests: the third arrives with pending full.
        @(negedge clk);
        set_req(1'b0, 32'h0000_000C, 32'h0000_0000, 4'b0000);
        @(negedge clk);
        set_req(1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000);
        @(negedge clk);
        set_req(1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0000);
        check("ovr k2 resp", {31'd0, response_enable}, 32'd1);
        check("ovr k2 data", data, 32'hDEAD_BEEF);
        check("ovr k2 overrun", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        request_enable = 1'b0;
        check("ovr k3 overrun", {31'd0, overrun}, 32'd1);
        check("ovr k3 resp", {31'd0, response_enable}, 32'd0);
        @(negedge clk);
        check("ovr k4 resp", {31'd0, response_enable}, 32'd1);
        check("ovr k4 data", data, 32'h1234_5678);
        pulses = 0;
        for (int k = 5; k <= 10; k++) begin
            @(negedge clk);
            if (response_enable) pulses++;
        end
        check("ovr extra pulses", pulses, 32'd0);
        check("ovr sticky", {31'd0, overrun}, 32'd1);
        check("ovr busy", {31'd0, busy}, 32'd0);

        // Reset one cycle after a write request: nothing may commit.
        @(negedge clk);
        set_req(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b1111);
        @(negedge clk);
        request_enable = 1'b0;
        rstn           = 1'b0;
        #1;
        check("mrst resp", {31'd0, response_enable}, 32'd0);
        check("mrst busy", {31'd0, busy}, 32'd0);
        check("mrst overrun", {31'd0, overrun}, 32'd0);
        check("mrst data", data, 32'd0);
        @(negedge clk);
        rstn   = 1'b1;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (response_enable) pulses++;
        end
        check("mrst pulses", pulses, 32'd0);
        do_txn(vecs[15], "mrst readback");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
